// File: rtl/dcm_freq_meter.sv
// dcm_freq_meter: measures the meas_clk period in clk cycles and decodes the dcm program code (period = 2^(k+1)).
// Define DCM_METER_TOL_EN to accept +/-1 cycle of period jitter. SYNC_STAGES must be >= 2.
module dcm_freq_meter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 10,
  parameter int unsigned LOCK_CNT    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             clear,
  output logic [2:0]       code_out,
  output logic             locked,
  output logic             changed,
  output logic             err,
  output logic [CNT_W-1:0] period_out
);

  localparam int unsigned      MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam int unsigned      NUM_CODES = 8;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_prev;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;

  logic [1:0]         state, state_nxt;
  logic [2:0]         cand, cand_nxt;
  logic [MATCH_W-1:0] match, match_nxt;
  logic [MATCH_W-1:0] new_match;
  logic               first_lock, first_nxt;
  logic [2:0]         code_nxt;
  logic               locked_nxt;
  logic               changed_nxt;
  logic               err_nxt;
  logic [CNT_W-1:0]   period_nxt;

  logic               dec_valid;
  logic [2:0]         dec_code;
  logic [CNT_W-1:0]   pow;

  // meas_clk is asynchronous: resynchronize, then detect the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], meas_clk};
      sync_prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~sync_prev;

  // Period counter: restarts at 1 on each rise so the value seen at a rise equals the period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Period decode; descending scan lets the lowest code win where tolerance windows overlap
  always_comb begin
    dec_valid = 1'b0;
    dec_code  = '0;
    pow       = '0;
    for (int k = int'(NUM_CODES) - 1; k >= 0; k--) begin
      pow = CNT_W'(32'd2 << k);
`ifdef DCM_METER_TOL_EN
      if ((cnt == pow) || (cnt == pow + CNT_W'(1)) || ((k > 0) && (cnt == pow - CNT_W'(1)))) begin
`else
      if (cnt == pow) begin
`endif
        dec_valid = 1'b1;
        dec_code  = 3'(k);
      end
    end
  end

  assign new_match = (dec_code == cand) ? (match + MATCH_W'(1)) : MATCH_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cand       <= '0;
      match      <= '0;
      first_lock <= 1'b1;
      code_out   <= '0;
      locked     <= 1'b0;
      changed    <= 1'b0;
      err        <= 1'b0;
      period_out <= '0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      match      <= match_nxt;
      first_lock <= first_nxt;
      code_out   <= code_nxt;
      locked     <= locked_nxt;
      changed    <= changed_nxt;
      err        <= err_nxt;
      period_out <= period_nxt;
    end
  end

  // Next-state and output logic; clear beats a coincident rise, a rise beats timeout
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    match_nxt   = match;
    first_nxt   = first_lock;
    code_nxt    = code_out;
    locked_nxt  = locked;
    changed_nxt = 1'b0;
    err_nxt     = err;
    period_nxt  = period_out;

    if (clear) begin
      state_nxt  = ST_IDLE;
      locked_nxt = 1'b0;
      err_nxt    = 1'b0;
      match_nxt  = '0;
      first_nxt  = 1'b1;
    end else if (rise) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_MEASURE;
          match_nxt = '0;
        end
        ST_MEASURE: begin
          period_nxt = cnt;
          if (!dec_valid) begin
            err_nxt   = 1'b1;
            match_nxt = '0;
          end else begin
            cand_nxt  = dec_code;
            match_nxt = new_match;
            if (new_match >= MATCH_W'(LOCK_CNT)) begin
              state_nxt   = ST_LOCKED;
              locked_nxt  = 1'b1;
              code_nxt    = dec_code;
              changed_nxt = first_lock | (dec_code != code_out);
              first_nxt   = 1'b0;
            end
          end
        end
        ST_LOCKED: begin
          period_nxt = cnt;
          if (!dec_valid) begin
            err_nxt    = 1'b1;
            locked_nxt = 1'b0;
            match_nxt  = '0;
            state_nxt  = ST_MEASURE;
          end else if (dec_code != code_out) begin
            cand_nxt   = dec_code;
            match_nxt  = MATCH_W'(1);
            locked_nxt = 1'b0;
            state_nxt  = ST_MEASURE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end else if ((cnt == CNT_MAX) && (state != ST_IDLE)) begin
      err_nxt    = 1'b1;
      locked_nxt = 1'b0;
      state_nxt  = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_dcm_freq_meter.sv
// Self-checking bench for dcm_freq_meter: directed scenarios plus randomized period streams
// compared against a period-history reference model.
module tb_dcm_freq_meter;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned LOCK_CNT    = 2;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             meas_clk;
  logic             clear;
  logic [2:0]       code_out;
  logic             locked;
  logic             changed;
  logic             err;
  logic [CNT_W-1:0] period_out;

  int checks = 0;
  int errors = 0;
  int chg_seen = 0;

  // Reference model: history of decoded periods in the current measurement run
  bit m_active;
  int m_hist[$];
  bit m_locked;
  bit m_err;
  int m_code;
  int m_period;
  bit m_first;
  int m_changes;
  int gap;

  dcm_freq_meter #(
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W),
    .LOCK_CNT   (LOCK_CNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .meas_clk  (meas_clk),
    .clear     (clear),
    .code_out  (code_out),
    .locked    (locked),
    .changed   (changed),
    .err       (err),
    .period_out(period_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && changed === 1'b1) chg_seen++;
  end

  function automatic int decode(input int p);
    int v;
    for (int k = 0; k < 8; k++) begin
      v = 2 << k;
`ifdef DCM_METER_TOL_EN
      if (p >= 2 && p >= v - 1 && p <= v + 1) return k;
`else
      if (p == v) return k;
`endif
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_hist.delete();
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_code   = 0;
    m_period = 0;
    m_first  = 1'b1;
    m_changes = 0;
    gap      = 0;
  endtask

  task automatic model_clear();
    m_active = 1'b0;
    m_hist.delete();
    m_locked = 1'b0;
    m_err    = 1'b0;
    m_first  = 1'b1;
  endtask

  task automatic model_timeout();
    if (m_active && gap > CNT_MAX) begin
      m_active = 1'b0;
      m_hist.delete();
      m_locked = 1'b0;
      m_err    = 1'b1;
    end
  endtask

  task automatic model_rise();
    int k;
    bit run;
    model_timeout();
    if (!m_active) begin
      m_active = 1'b1;
      m_hist.delete();
      return;
    end
    m_period = gap;
    k = decode(gap);
    if (k < 0) m_err = 1'b1;
    m_hist.push_back(k);
    if (m_hist.size() > LOCK_CNT) void'(m_hist.pop_front());
    run = (m_hist.size() == LOCK_CNT) && (k >= 0);
    foreach (m_hist[i]) if (m_hist[i] != k) run = 1'b0;
    if (run && !m_locked) begin
      if (m_first || k != m_code) m_changes++;
      m_code  = k;
      m_first = 1'b0;
    end
    m_locked = run;
  endtask

  // One meas_clk period of n clk cycles, starting with a rising edge
  task automatic pulse(input int n);
    model_rise();
    meas_clk = 1'b1;
    repeat (n / 2) @(negedge clk);
    meas_clk = 1'b0;
    repeat (n - n / 2) @(negedge clk);
    gap = n;
  endtask

  task automatic idle(input int c);
    meas_clk = 1'b0;
    repeat (c) @(negedge clk);
    gap += c;
    model_timeout();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    gap += 1;
  endtask

  // Rising edge whose synchronized rise lands on the same clk edge as clear
  task automatic pulse_clear(input int n);
    meas_clk = 1'b1;
    repeat (SYNC_STAGES) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (n / 2 - SYNC_STAGES - 1) @(negedge clk);
    meas_clk = 1'b0;
    repeat (n - n / 2) @(negedge clk);
    model_clear();
    gap = n;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    meas_clk = 1'b0;
    clear = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      meas_clk = ~meas_clk;
    end
    #1;
    checks++; if (code_out !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", code_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %0b expected 0", changed); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++; if (period_out !== '0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_out); end
    meas_clk = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle(4);
  endtask

  task automatic test_lock_basic();
    int base = chg_seen;
    for (int i = 1; i <= 6; i++) begin
      pulse(8);
      #1;
      checks++;
      if (locked !== (i >= 3)) begin errors++; $display("FAIL lock8_locked[%0d]: got %0b expected %0b", i, locked, i >= 3); end
    end
    checks++; if (code_out !== 3'd2) begin errors++; $display("FAIL lock8_code: got %0d expected 2", code_out); end
    checks++; if (period_out !== CNT_W'(8)) begin errors++; $display("FAIL lock8_period: got %0d expected 8", period_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lock8_err: got %0b expected 0", err); end
    checks++; if (chg_seen - base !== 1) begin errors++; $display("FAIL lock8_changed: got %0d pulses expected 1", chg_seen - base); end
  endtask

  task automatic test_reprogram();
    int base = chg_seen;
    for (int i = 1; i <= 3; i++) begin
      pulse(16);
      #1;
      checks++;
      if (locked !== (i != 2)) begin errors++; $display("FAIL reprog16_locked[%0d]: got %0b expected %0b", i, locked, i != 2); end
    end
    checks++; if (code_out !== 3'd3) begin errors++; $display("FAIL reprog16_code: got %0d expected 3", code_out); end
    checks++; if (chg_seen - base !== 1) begin errors++; $display("FAIL reprog16_changed: got %0d pulses expected 1", chg_seen - base); end
    repeat (3) pulse(256);
    #1;
    checks++; if (locked !== 1'b1 || code_out !== 3'd7) begin errors++; $display("FAIL reprog256: got locked %0b code %0d expected 1/7", locked, code_out); end
    checks++; if (period_out !== CNT_W'(256)) begin errors++; $display("FAIL reprog256_period: got %0d expected 256", period_out); end
    repeat (4) pulse(2);
    idle(4);
    checks++; if (locked !== 1'b1 || code_out !== 3'd0) begin errors++; $display("FAIL reprog2: got locked %0b code %0d expected 1/0", locked, code_out); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reprog_err: got %0b expected 0", err); end
    checks++; if (chg_seen - base !== 3) begin errors++; $display("FAIL reprog_changed: got %0d pulses expected 3", chg_seen - base); end
  endtask

  task automatic test_invalid();
    repeat (3) pulse(12);
    #1;
    checks++; if (err !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL inv12: got err %0b locked %0b expected 1/0", err, locked); end
    checks++; if (period_out !== CNT_W'(12)) begin errors++; $display("FAIL inv12_period: got %0d expected 12", period_out); end
    do_clear();
    repeat (4) pulse(9);
    #1;
`ifdef DCM_METER_TOL_EN
    checks++; if (err !== 1'b0 || locked !== 1'b1 || code_out !== 3'd2) begin
      errors++; $display("FAIL tol9: got err %0b locked %0b code %0d expected 0/1/2", err, locked, code_out); end
`else
    checks++; if (err !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL exact9: got err %0b locked %0b expected 1/0", err, locked); end
`endif
    checks++; if (err !== m_err || locked !== m_locked) begin
      errors++; $display("FAIL inv_model: got err %0b locked %0b expected %0b/%0b", err, locked, m_err, m_locked); end
  endtask

  task automatic test_timeout();
    int base;
    do_clear();
    repeat (3) pulse(8);
    #1;
    checks++; if (locked !== 1'b1 || err !== 1'b0 || code_out !== 3'd2) begin
      errors++; $display("FAIL to_prelock: got locked %0b err %0b code %0d expected 1/0/2", locked, err, code_out); end
    idle(1100);
    checks++; if (err !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL to_stop: got err %0b locked %0b expected 1/0", err, locked); end
    base = chg_seen;
    for (int i = 1; i <= 4; i++) begin
      pulse(4);
      #1;
      checks++;
      if (locked !== (i >= 3)) begin errors++; $display("FAIL to_relock[%0d]: got %0b expected %0b", i, locked, i >= 3); end
    end
    checks++; if (code_out !== 3'd1 || err !== 1'b1) begin errors++; $display("FAIL to_code: got code %0d err %0b expected 1/1", code_out, err); end
    checks++; if (chg_seen - base !== 1) begin errors++; $display("FAIL to_changed: got %0d pulses expected 1", chg_seen - base); end
  endtask

  task automatic test_clear();
    int base;
    repeat (3) pulse(8);
    #1;
    checks++; if (locked !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL clr_pre: got locked %0b err %0b expected 1/1", locked, err); end
    do_clear();
    #1;
    checks++; if (locked !== 1'b0 || err !== 1'b0 || code_out !== 3'd2) begin
      errors++; $display("FAIL clr_now: got locked %0b err %0b code %0d expected 0/0/2", locked, err, code_out); end
    base = chg_seen;
    for (int i = 1; i <= 3; i++) begin
      pulse(8);
      #1;
      checks++;
      if (locked !== (i == 3)) begin errors++; $display("FAIL clr_relock[%0d]: got %0b expected %0b", i, locked, i == 3); end
    end
    checks++; if (chg_seen - base !== 1) begin errors++; $display("FAIL clr_changed: got %0d pulses expected 1", chg_seen - base); end
    pulse_clear(8);
    #1;
    checks++; if (locked !== 1'b0 || err !== 1'b0 || code_out !== 3'd2 || period_out !== CNT_W'(8)) begin
      errors++; $display("FAIL clr_coinc: got locked %0b err %0b code %0d period %0d expected 0/0/2/8", locked, err, code_out, period_out); end
    for (int i = 1; i <= 3; i++) begin
      pulse(8);
      #1;
      checks++;
      if (locked !== (i == 3)) begin errors++; $display("FAIL coinc_relock[%0d]: got %0b expected %0b", i, locked, i == 3); end
    end
  endtask

  task automatic test_random();
    int tbl[18] = '{2, 3, 4, 8, 16, 32, 64, 128, 256, 6, 9, 12, 15, 17, 100, 255, 257, 300};
    int p;
    int reps;
    for (int s = 0; s < 30; s++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      p = tbl[$urandom_range(0, 17)];
      reps = $urandom_range(1, 4);
      for (int r = 0; r < reps; r++) begin
        pulse(p);
        if (p >= 4) begin
          #1;
          checks++; if (locked !== m_locked) begin errors++; $display("FAIL rnd_locked s%0d p%0d: got %0b expected %0b", s, p, locked, m_locked); end
          checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err s%0d p%0d: got %0b expected %0b", s, p, err, m_err); end
          checks++; if (code_out !== 3'(m_code)) begin errors++; $display("FAIL rnd_code s%0d p%0d: got %0d expected %0d", s, p, code_out, m_code); end
          checks++; if (period_out !== CNT_W'(m_period)) begin errors++; $display("FAIL rnd_period s%0d p%0d: got %0d expected %0d", s, p, period_out, m_period); end
          checks++; if (chg_seen !== m_changes) begin errors++; $display("FAIL rnd_changed s%0d p%0d: got %0d expected %0d", s, p, chg_seen, m_changes); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_reprogram();
    test_invalid();
    test_timeout();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_freq_meter.md
Name: dcm_freq_meter

Overview:
- Frequency decoder for the dcm output clocks: measures the period of a generated clock (clk_1) in system-clock cycles and recovers the 3-bit program code that produced it.
- Sits next to the dcm as its read-back/check end. It converts the generated clock back into a prog value and an update-style strobe, so software or a checker can confirm the programmed divider.
- Decoding rule: code k corresponds to a period of exactly 2^(k+1) clk cycles (k = 0..7, period 2..256).

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the meas_clk synchronizer (minimum 2).
- CNT_W, 10, width of the period counter. Must satisfy 2^CNT_W - 1 > 256.
- LOCK_CNT, 2, number of consecutive identical decoded periods required to declare lock.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- meas_clk  input  1  clock under test (dcm clk_1/clk_2). Treated as asynchronous data.
- clear  input  1  synchronous, single-cycle. Drops lock and restarts measurement.
- code_out  output  3  decoded program code. Valid only while locked = 1.
- locked  output  1  high while LOCK_CNT consecutive periods have decoded to code_out.
- changed  output  1  one-cycle pulse when code_out takes a new value while locked.
- err  output  1  sticky flag: non-power-of-two period or timeout seen since the last clear/reset.
- period_out  output  CNT_W  last measured raw period, in clk cycles.

Behaviour:
- Reset (rst = 0, asynchronous):
  - code_out = 0, locked = 0, changed = 0, err = 0, period_out = 0.
  - Synchronizer = 0, counter = 0, state = IDLE.
- Synchronizer and edge detection:
  - meas_clk passes through SYNC_STAGES flops.
  - rise = sync_last & ~sync_prev, one cycle wide.
  - Latency from a meas_clk edge to rise is SYNC_STAGES+1 cycles. This latency is constant, so measured periods are unaffected.
- Counter:
  - Reset to 1 on each rise; otherwise increments.
  - Saturates at 2^CNT_W - 1, which sets timeout.
- State machine:
  - IDLE: wait for the first rise. On rise go to MEASURE with match count = 0.
  - MEASURE: on each rise, latch period P = counter into period_out, then decode.
    - Valid P (exact power of two in 2..256): if the decoded k equals the previous candidate, match count + 1, else candidate = k and match count = 1. When match count reaches LOCK_CNT, go to LOCKED and set code_out = k.
    - Invalid P: err = 1, match count = 0, stay in MEASURE.
  - LOCKED: on each rise, latch and decode P.
    - Same k: stay.
    - Different valid k: candidate = k, match count = 1, locked = 0, go to MEASURE. code_out holds its old value until relock.
    - Invalid P: err = 1, locked = 0, go to MEASURE.
- Timeout: counter saturates in any state except IDLE → err = 1, locked = 0, state = IDLE.
- changed: pulses for one cycle on entry to LOCKED when the new code_out differs from the value held before. The first lock after reset/clear always pulses.
- clear:
  - Forces state = IDLE, locked = 0, err = 0, match count = 0.
  - code_out and period_out are held.
  - clear and rise in the same cycle: clear wins and that rise is ignored.
- Timing: locked asserts on the same cycle as the LOCK_CNT-th qualifying rise is seen, i.e. registered one cycle after that rise pulse.
- Width rule: period compare is unsigned, CNT_W bits. Periods above 256 are invalid, not decoded.

Optional Feature:
- Macro: DCM_METER_TOL_EN.
- Defined: a period within ±1 cycle of 2^(k+1) decodes to k. This covers synchronizer jitter on asynchronous meas_clk. For k = 0 only 2 and 3 are accepted; a period of 1 is invalid.
- Undefined: only exact powers of two decode; any other period sets err.

Test Plan:
- Reset with meas_clk toggling: hold rst = 0 for 3 cycles → all outputs 0. Release → locked stays 0 until two full periods have been measured.
- meas_clk = clk/8 (code 2) → period_out = 8, code_out = 2. locked rises after the 2nd matching rise; changed pulses once.
- Reprogram meas_clk from clk/8 to clk/16 (code 3) → locked drops at the first 16-cycle period, relocks with code_out = 3, one changed pulse. Then clk/256 → code_out = 7; then clk/2 → code_out = 0.
- meas_clk with period 12 → err = 1, locked = 0. With DCM_METER_TOL_EN defined, period 9 → code_out = 2, err = 0.
- meas_clk stopped for 1100 cycles while locked → err = 1, locked = 0, state IDLE. Restart at clk/4 → relock with code_out = 1.
- Assert clear while locked, and clear coincident with a rise → locked = 0, err = 0, code_out held. That rise is ignored, and relock needs LOCK_CNT new periods.
